// File: rtl/bin_to_bcd.sv
// bin_to_bcd: registered 5-bit binary to two-digit BCD converter (shift-add-3),
// with a compact 0..19 output that saturates and flags overflow above 19.
module bin_to_bcd (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] inp,
    output logic [4:0] op,
    output logic [1:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       ovf
);
    logic [7:0] dd;
    logic [4:0] op_d, op_q;
    logic [1:0] tens_d, tens_q;
    logic [3:0] ones_d, ones_q;
    logic       ovf_d, ovf_q;

    // Input bits shift in MSB first; each nibble is corrected before every shift.
    always_comb begin
        dd = 8'd0;
        for (int i = 4; i >= 0; i--) begin
            dd[3:0] = (dd[3:0] >= 4'd5) ? dd[3:0] + 4'd3 : dd[3:0];
            dd[7:4] = (dd[7:4] >= 4'd5) ? dd[7:4] + 4'd3 : dd[7:4];
            dd = {dd[6:0], inp[i]};
        end
        ones_d = dd[3:0];
        tens_d = dd[5:4];
        ovf_d  = |dd[7:5];
        op_d   = ovf_d ? 5'b1_1001 : {dd[4], dd[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 5'd0;
            tens_q <= 2'd0;
            ones_q <= 4'd0;
            ovf_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            ovf_q  <= ovf_d;
        end
    end

    assign op       = op_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: table-driven vectors plus directed reset and latency sequences.
module tb_bin_to_bcd;
    logic       clk, rst;
    logic [4:0] inp;
    logic [4:0] op;
    logic [1:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       ovf;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] i;
        logic [4:0] op;
        logic [1:0] t;
        logic [3:0] o;
        logic       v;
    } vec_t;

    vec_t vt[20];

    bin_to_bcd dut (
        .clk(clk), .rst(rst), .inp(inp),
        .op(op), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [4:0] eop, input logic [1:0] et,
                       input logic [3:0] eo, input logic ev);
        n_cmp++;
        if ({op, bcd_tens, bcd_ones, ovf} !== {eop, et, eo, ev}) begin
            n_err++;
            $display("FAIL %s: got op=%b tens=%0d ones=%0d ovf=%b, want op=%b tens=%0d ones=%0d ovf=%b",
                     nm, op, bcd_tens, bcd_ones, ovf, eop, et, eo, ev);
        end
    endtask

    task automatic step(input logic [4:0] v);
        @(negedge clk);
        inp = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            vt[k].i  = 5'(k);
            vt[k].t  = 2'(k / 10);
            vt[k].o  = 4'(k % 10);
            vt[k].op = {(k >= 10) ? 1'b1 : 1'b0, 4'(k % 10)};
            vt[k].v  = 1'b0;
        end
        vt[16] = '{5'd19, 5'b1_1001, 2'd1, 4'd9, 1'b0};
        vt[17] = '{5'd20, 5'b1_1001, 2'd2, 4'd0, 1'b1};
        vt[18] = '{5'd31, 5'b1_1001, 2'd3, 4'd1, 1'b1};
        vt[19] = '{5'd30, 5'b1_1001, 2'd3, 4'd0, 1'b1};

        rst = 1'b1;
        inp = 5'd0;
        #1;
        chk("reset_state", 5'd0, 2'd0, 4'd0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        step(5'd5);
        chk("pre_reset_5", 5'b0_0101, 2'd0, 4'd5, 1'b0);
        #2;
        inp = 5'd13;
        rst = 1'b1;
        #1;
        chk("async_reset_inp13", 5'd0, 2'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_inp13", 5'b1_0011, 2'd1, 4'd3, 1'b0);

        for (int k = 0; k < 20; k++) begin
            step(vt[k].i);
            chk($sformatf("vec_inp%0d", vt[k].i), vt[k].op, vt[k].t, vt[k].o, vt[k].v);
        end

        step(5'd9);
        chk("boundary_9", 5'b0_1001, 2'd0, 4'd9, 1'b0);
        step(5'd10);
        chk("boundary_10", 5'b1_0000, 2'd1, 4'd0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            step(5'd20);
            chk($sformatf("hold20_%0d", k), 5'b1_1001, 2'd2, 4'd0, 1'b1);
        end

        step(5'd7);
        chk("lat_7", 5'b0_0111, 2'd0, 4'd7, 1'b0);
        step(5'd10);
        chk("lat_10", 5'b1_0000, 2'd1, 4'd0, 1'b0);
        step(5'd25);
        chk("lat_25", 5'b1_1001, 2'd2, 4'd5, 1'b1);
        step(5'd0);
        chk("lat_0", 5'b0_0000, 2'd0, 4'd0, 1'b0);
        @(negedge clk);
        inp = 5'd31;
        #1;
        chk("lat_no_early_update", 5'b0_0000, 2'd0, 4'd0, 1'b0);

        step(5'd18);
        chk("mid_pre_18", 5'b1_1000, 2'd1, 4'd8, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_clear", 5'd0, 2'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_held_in_reset", 5'd0, 2'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_after_release", 5'd0, 2'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_first_edge_18", 5'b1_1000, 2'd1, 4'd8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
